// File: rtl/csr_intr_unit.sv
// csr_intr_unit: machine-mode CSRs with synchronised, edge-detected external interrupt
module csr_intr_unit (
  input  logic        clk,
  input  logic        RST,
  input  logic        ext_irq,
  input  logic        int_taken,
  input  logic        csr_WE,
  input  logic        mret_exec,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic        intr,
  output logic [31:0] rd,
  output logic [31:0] mepc_out,
  output logic [31:0] mtvec_out
);
  logic s1, s2, s_prev, pending, edge_det;
  logic mie_b, mpie, meie;
  logic [31:0] mtvec, mepc, mcause, mstatus, mie_r;
  logic wr_en, mret_en;
  assign edge_det = s2 & ~s_prev;
  assign wr_en = csr_WE & ~int_taken;
  assign mret_en = mret_exec & ~int_taken;
  assign mstatus = {24'b0, mpie, 3'b0, mie_b, 3'b0};
  assign mie_r = {20'b0, meie, 11'b0};
  assign intr = pending & mie_b & meie;
  assign mepc_out = mepc;
  assign mtvec_out = mtvec;
  always_comb
    rd = csr_addr == 12'h300 ? mstatus :
         csr_addr == 12'h304 ? mie_r :
         csr_addr == 12'h305 ? mtvec :
         csr_addr == 12'h341 ? mepc :
         csr_addr == 12'h342 ? mcause : 32'h0;
  always_ff @(posedge clk)
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s_prev <= 1'b0;
      pending <= 1'b0;
      mie_b <= 1'b0;
      mpie <= 1'b0;
      meie <= 1'b0;
      mtvec <= 32'h0;
      mepc <= 32'h0;
      mcause <= 32'h0;
    end else begin
      s1 <= ext_irq;
      s2 <= s1;
      s_prev <= s2;
      pending <= edge_det | (pending & ~int_taken);
      if (int_taken) begin
        mepc <= {pc[31:2], 2'b00};
        mpie <= mie_b;
        mie_b <= 1'b0;
        mcause <= 32'h8000_000B;
      end
      if (wr_en && csr_addr == 12'h300) begin
        mie_b <= wd[3];
        mpie <= wd[7];
      end
      if (wr_en && csr_addr == 12'h304) meie <= wd[11];
      if (wr_en && csr_addr == 12'h305) mtvec <= {wd[31:2], 2'b00};
      if (wr_en && csr_addr == 12'h341) mepc <= {wd[31:2], 2'b00};
      // an MRET in the same cycle as an mstatus write wins
      if (mret_en) begin
        mie_b <= mpie;
        mpie <= 1'b1;
      end
    end
endmodule

// File: tb/tb_csr_intr_unit.sv
// tb_csr_intr_unit: directed scenario tests for csr_intr_unit
module tb_csr_intr_unit;
  logic clk = 1'b0, RST = 1'b0, ext_irq = 1'b0, int_taken = 1'b0, csr_WE = 1'b0, mret_exec = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] wd = 32'h0, pc = 32'h0;
  logic intr;
  logic [31:0] rd, mepc_out, mtvec_out;
  int n_cmp = 0, n_bad = 0;

  csr_intr_unit dut (
    .clk(clk), .RST(RST), .ext_irq(ext_irq), .int_taken(int_taken), .csr_WE(csr_WE),
    .mret_exec(mret_exec), .csr_addr(csr_addr), .wd(wd), .pc(pc), .intr(intr), .rd(rd),
    .mepc_out(mepc_out), .mtvec_out(mtvec_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a;
    wd = d;
    csr_WE = 1'b1;
    step();
    csr_WE = 1'b0;
  endtask

  task automatic rdv(input logic [11:0] a, output logic [31:0] v);
    csr_addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [5] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342};
    logic [31:0] v;
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_cmp++;
    if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr got %b want 0", intr); end
    foreach (addrs[i]) begin
      rdv(addrs[i], v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_rd[%h] got %h want 0", addrs[i], v); end
    end
  endtask

  task automatic test_enable_request();
    logic [31:0] v;
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    rdv(12'h304, v);
    n_cmp++;
    if (v !== 32'h800) begin n_bad++; $display("FAIL mie_rd got %h want 800", v); end
    ext_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (intr !== (i == 2)) begin n_bad++; $display("FAIL latency_edge%0d got %b want %b", i, intr, i == 2); end
    end
    pc = 32'h0000_0104;
    int_taken = 1'b1;
    step();
    int_taken = 1'b0;
    n_cmp++;
    if (mepc_out !== 32'h104) begin n_bad++; $display("FAIL entry_mepc got %h want 104", mepc_out); end
    rdv(12'h342, v);
    n_cmp++;
    if (v !== 32'h8000_000B) begin n_bad++; $display("FAIL entry_mcause got %h want 8000000b", v); end
    rdv(12'h300, v);
    n_cmp++;
    if (v !== 32'h80) begin n_bad++; $display("FAIL entry_mstatus got %h want 80", v); end
    n_cmp++;
    if (intr !== 1'b0) begin n_bad++; $display("FAIL entry_intr got %b want 0", intr); end
    ext_irq = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_mret();
    logic [31:0] v;
    mret_exec = 1'b1;
    step();
    mret_exec = 1'b0;
    rdv(12'h300, v);
    n_cmp++;
    if (v !== 32'h88) begin n_bad++; $display("FAIL mret_mstatus got %h want 88", v); end
  endtask

  task automatic test_masked();
    wr(12'h300, 32'h0);
    ext_irq = 1'b1;
    repeat (3) step();
    ext_irq = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (intr !== 1'b0) begin n_bad++; $display("FAIL masked_intr got %b want 0", intr); end
    wr(12'h300, 32'h8);
    n_cmp++;
    if (intr !== 1'b1) begin n_bad++; $display("FAIL unmask_intr got %b want 1", intr); end
    int_taken = 1'b1;
    step();
    int_taken = 1'b0;
    n_cmp++;
    if (intr !== 1'b0) begin n_bad++; $display("FAIL masked_clear got %b want 0", intr); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    csr_addr = 12'h305;
    wd = 32'h200;
    csr_WE = 1'b1;
    int_taken = 1'b1;
    step();
    csr_WE = 1'b0;
    int_taken = 1'b0;
    n_cmp++;
    if (mtvec_out !== 32'h0) begin n_bad++; $display("FAIL collide_mtvec got %h want 0", mtvec_out); end
    wr(12'h305, 32'h200);
    n_cmp++;
    if (mtvec_out !== 32'h200) begin n_bad++; $display("FAIL mtvec_wr got %h want 200", mtvec_out); end
    wr(12'h305, 32'h203);
    rdv(12'h305, v);
    n_cmp++;
    if (v !== 32'h200) begin n_bad++; $display("FAIL mtvec_align got %h want 200", v); end
    wr(12'h341, 32'h107);
    n_cmp++;
    if (mepc_out !== 32'h104) begin n_bad++; $display("FAIL mepc_align got %h want 104", mepc_out); end
    wr(12'h342, 32'h0);
    rdv(12'h342, v);
    n_cmp++;
    if (v !== 32'h8000_000B) begin n_bad++; $display("FAIL mcause_ro got %h want 8000000b", v); end
    mret_exec = 1'b1;
    int_taken = 1'b1;
    step();
    mret_exec = 1'b0;
    int_taken = 1'b0;
    rdv(12'h300, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL collide_mret got %h want 0", v); end
  endtask

  task automatic test_held();
    wr(12'h300, 32'h8);
    ext_irq = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      int_taken = (i == 5);
      csr_addr = 12'h300;
      wd = 32'h8;
      csr_WE = (i == 6);
      step();
      n_cmp++;
      if (intr !== (i == 3 || i == 4)) begin n_bad++; $display("FAIL held_cyc%0d got %b want %b", i, intr, i == 3 || i == 4); end
    end
    int_taken = 1'b0;
    csr_WE = 1'b0;
    ext_irq = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    logic [11:0] addrs [5] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342};
    logic [31:0] v;
    wr(12'h341, 32'h104);
    ext_irq = 1'b1;
    repeat (3) step();
    ext_irq = 1'b0;
    n_cmp++;
    if (intr !== 1'b1) begin n_bad++; $display("FAIL pre_reset_intr got %b want 1", intr); end
    rdv(12'h7C0, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_pre got %h want 0", v); end
    RST = 1'b1;
    int_taken = 1'b1;
    step();
    RST = 1'b0;
    int_taken = 1'b0;
    n_cmp++;
    if (intr !== 1'b0 || mepc_out !== 32'h0 || mtvec_out !== 32'h0) begin
      n_bad++; $display("FAIL post_reset got intr=%b mepc=%h mtvec=%h want 0/0/0", intr, mepc_out, mtvec_out);
    end
    foreach (addrs[i]) begin
      rdv(addrs[i], v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rd[%h] got %h want 0", addrs[i], v); end
    end
    rdv(12'h7C0, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_post got %h want 0", v); end
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    n_cmp++;
    if (intr !== 1'b0) begin n_bad++; $display("FAIL pending_lost got %b want 0", intr); end
  endtask

  initial begin
    test_reset();
    test_enable_request();
    test_mret();
    test_masked();
    test_collision();
    test_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_intr_unit.md
CSR_INTR_UNIT -- requirements
Module: csr_intr_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: ext_irq  in  1  external interrupt request, asynchronous to clk, level.
REQ-004 SHALL have: int_taken  in  1  one-cycle pulse from the control FSM INTERRUPT state.
REQ-005 SHALL have: csr_WE  in  1  CSR write enable from the control FSM.
REQ-006 SHALL have: mret_exec  in  1  one-cycle pulse while an MRET executes.
REQ-007 SHALL have: csr_addr  in  12  CSR address (ir[31:20]).
REQ-008 SHALL have: wd  in  32  CSR write data.
REQ-009 SHALL have: pc  in  32  current PC, captured into mepc on interrupt entry.
REQ-010 SHALL have: intr  out  1  interrupt request to the control FSM.
REQ-011 SHALL have: rd  out  32  CSR read data.
REQ-012 SHALL have: mepc_out  out  32  and  mtvec_out  out  32  for the PC source mux.

Function
REQ-013 SHALL implement mstatus 0x300 (bit3 MIE, bit7 MPIE, others read 0), mie 0x304 (bit11 MEIE only), mtvec 0x305, mepc 0x341 and mcause 0x342.
REQ-014 SHALL drive rd combinationally from csr_addr; unimplemented addresses SHALL read 0x00000000.
REQ-015 SHALL, when csr_WE=1 and int_taken=0, write wd into the addressed CSR on the rising edge; unimplemented addresses ignore the write; mtvec and mepc bits[1:0] SHALL be stored as 0.
REQ-016 SHALL treat mcause as read-only to csr_WE; only int_taken updates it.
REQ-017 SHALL synchronise ext_irq through two flops (s1, s2), then register s2 into s_prev; edge = s2 & ~s_prev.
REQ-018 SHALL set the pending flop on edge; SHALL clear pending on int_taken; if edge and int_taken occur in the same cycle, pending SHALL remain 1.
REQ-019 SHALL drive intr = pending & MIE & MEIE, combinationally from registered state.
REQ-020 SHALL, on int_taken, load mepc <= {pc[31:2],2'b00}, MPIE <= MIE, MIE <= 0 and mcause <= 0x8000000B in one edge.
REQ-021 SHALL, on mret_exec with int_taken=0, load MIE <= MPIE and MPIE <= 1.
REQ-022 SHALL give int_taken priority: if it coincides with csr_WE or mret_exec, the write or mret SHALL be dropped.
REQ-023 SHALL detect a level held high as one edge only; a new request requires ext_irq to return low for at least 2 cycles.
REQ-024 Latency: with ext_irq first sampled high at edge N, pending (and intr if enabled) SHALL be 1 after edge N+2.
REQ-025 SHALL continuously drive mepc_out = mepc and mtvec_out = mtvec.

Reset
REQ-026 SHALL, with RST=1 at a rising edge, clear s1, s2, s_prev, pending, mstatus, mie, mtvec, mepc and mcause to 0, so intr=0 and rd=0 for all addresses.
REQ-027 SHALL give RST priority over all other inputs, including mid-interrupt entry; a pending request SHALL be lost.

Verification
REQ-028 Enable then request: write 0x300=0x8, write 0x304=0x800, raise ext_irq at edge N -> intr=1 after edge N+2; pulse int_taken with pc=0x0000_0104 -> mepc=0x104, mcause=0x8000000B, mstatus=0x80, intr=0.
REQ-029 Masked request: MIE=0, ext_irq pulse of 3 cycles -> pending=1, intr=0; then write 0x300=0x8 -> intr=1 next cycle.
REQ-030 MRET restore: after REQ-028, pulse mret_exec -> mstatus reads 0x88.
REQ-031 Collision: csr_WE=1, csr_addr=0x305, wd=0x0000_0200 with int_taken=1 in the same cycle -> mtvec unchanged (0); the next write stores 0x200; wd=0x203 reads back 0x200.
REQ-032 Held level: ext_irq held high for 20 cycles with int_taken at cycle 5 -> intr=0 from cycle 6 onward, no re-assertion.
REQ-033 Reset mid-operation: pending=1, mepc=0x104, assert RST one cycle -> all CSRs read 0, intr=0; an unmapped address 0x7C0 reads 0 before and after reset.
